// File: rtl/piso_arb_pkg.sv
// Shared types and helpers for the round-robin serialiser.
package piso_arb_pkg;

    typedef enum logic {ST_IDLE, ST_SHIFT} piso_arb_state_t;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/piso_shifter.sv
// LSB-first parallel-in/serial-out shifter; a load takes priority over a shift.
module piso_shifter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  serial_out
);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  serial_q, serial_d;

    // Bit 0 goes straight to the output on load; the rest waits in the register.
    always_comb begin
        shreg_d  = shreg_q;
        serial_d = serial_q;
        if (load) begin
            shreg_d  = din >> 1;
            serial_d = din[0];
        end else if (shift_en) begin
            shreg_d  = shreg_q >> 1;
            serial_d = shreg_q[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q  <= '0;
            serial_q <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            serial_q <= serial_d;
        end
    end

    assign serial_out = serial_q;

endmodule

// File: rtl/piso_serial_arbiter.sv
// Round-robin arbiter feeding one shared LSB-first serialiser with frame markers.
module piso_serial_arbiter
    import piso_arb_pkg::*;
#(
    parameter int  DATA_WIDTH   = 8,
    parameter int  NUM_REQ      = 4,
    parameter int  CLKS_PER_BIT = 1,
    localparam int ID_W         = clog2_min1(NUM_REQ),
    localparam int DIV_W        = clog2_min1(CLKS_PER_BIT),
    localparam int CNT_W        = $clog2(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          serial_out,
    output logic                          serial_valid,
    output logic                          frame_start,
    output logic                          frame_end,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    piso_arb_state_t   state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;

    logic                  win_found;
    logic [ID_W-1:0]       win_idx;
    logic                  handshake;
    logic                  div_last;
    logic                  bit_last;
    logic                  sh_load;
    logic                  sh_shift;
    logic [DATA_WIDTH-1:0] sh_din;

    // Search starts one past the last grant so the previous winner goes last.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign handshake = (state_q == ST_IDLE) && !flush && win_found;
    assign div_last  = (div_cnt_q == DIV_W'(CLKS_PER_BIT - 1));
    assign bit_last  = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));

    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_d   = ST_SHIFT;
                    ptr_d     = win_idx;
                    grant_d   = win_idx;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (flush) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end else if (div_last) begin
                    div_cnt_d = '0;
                    if (bit_last) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= ID_W'(NUM_REQ - 1);
            grant_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    // A flush reloads zeros so the line returns low; the final shift of a frame
    // pulls in the zero fill and does the same.
    assign sh_load  = handshake || ((state_q == ST_SHIFT) && flush);
    assign sh_shift = (state_q == ST_SHIFT) && !flush && div_last;
    assign sh_din   = handshake ? req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;

    piso_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (sh_load),
        .shift_en   (sh_shift),
        .din        (sh_din),
        .serial_out (serial_out)
    );

    assign serial_valid = (state_q == ST_SHIFT);
    assign busy         = (state_q == ST_SHIFT);
    assign frame_start  = (state_q == ST_SHIFT) && (bit_cnt_q == '0) && (div_cnt_q == '0);
    assign frame_end    = (state_q == ST_SHIFT) && bit_last && div_last;
    assign grant_id     = grant_q;

endmodule

// File: tb/tb_piso_serial_arbiter.sv
// Scoreboard bench: directed words per requester, expected frames queued, monitor checks each frame.
module tb_piso_serial_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        flush;
    logic [3:0]  rv1, rr1, rv3, rr3;
    logic [31:0] rd1, rd3;
    logic        so1, sv1, fs1, fe1, bz1;
    logic        so3, sv3, fs3, fe3, bz3;
    logic [1:0]  gid1, gid3;

    piso_serial_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req_valid(rv1), .req_data(rd1), .req_ready(rr1),
        .serial_out(so1), .serial_valid(sv1), .frame_start(fs1), .frame_end(fe1),
        .grant_id(gid1), .busy(bz1)
    );

    piso_serial_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .CLKS_PER_BIT(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .flush(1'b0),
        .req_valid(rv3), .req_data(rd3), .req_ready(rr3),
        .serial_out(so3), .serial_valid(sv3), .frame_start(fs3), .frame_end(fe3),
        .grant_id(gid3), .busy(bz3)
    );

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        int         len;
        bit         ab;
        int         gap;
    } exp_t;

    exp_t       exq1[$];
    exp_t       exq3[$];
    logic [7:0] wq1[4][$];
    logic [7:0] wq3[4][$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] cap[2];
    int          flen[2];
    bit          inf[2];
    int          idle[2];
    int          gapv[2];
    logic [1:0]  fid[2];
    bit          fsbad[2];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] id, input logic [7:0] d, input int len,
                                input bit ab, input int gap);
        exp_t e;
        e.id = id; e.data = d; e.len = len; e.ab = ab; e.gap = gap;
        return e;
    endfunction

    task automatic finish_frame(input int k, input bit ab, input int cpb);
        exp_t        e;
        logic [63:0] ev;
        bit          empty;
        empty = (k == 0) ? (exq1.size() == 0) : (exq3.size() == 0);
        if (empty) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d_unexpected_frame: got id %0d len %0d want no frame", k, fid[k], flen[k]);
        end else begin
            if (k == 0) e = exq1.pop_front();
            else        e = exq3.pop_front();
            ev = '0;
            for (int c = 0; c < e.len; c++) ev[c] = e.data[c / cpb];
            chk($sformatf("dut%0d_grant_id", k), 64'(fid[k]), 64'(e.id));
            chk($sformatf("dut%0d_frame_len", k), 64'(flen[k]), 64'(e.len));
            chk($sformatf("dut%0d_aborted", k), 64'(ab), 64'(e.ab));
            chk($sformatf("dut%0d_bits", k), cap[k], ev);
            chk($sformatf("dut%0d_frame_start_first_only", k), 64'(fsbad[k]), 64'(0));
            if (e.gap >= 0) chk($sformatf("dut%0d_idle_gap", k), 64'(gapv[k]), 64'(e.gap));
        end
        inf[k]  = 1'b0;
        idle[k] = ab ? 1 : 0;
    endtask

    task automatic mon(input int k, input int cpb, input logic sv, input logic so,
                       input logic fs, input logic fe, input logic [1:0] gid);
        if (inf[k]) begin
            if (sv === 1'b1) begin
                cap[k][flen[k]] = so;
                flen[k]++;
                if (fs) fsbad[k] = 1'b1;
                if (fe) finish_frame(k, 1'b0, cpb);
            end else begin
                finish_frame(k, 1'b1, cpb);
            end
        end else if (sv === 1'b1) begin
            inf[k]   = 1'b1;
            gapv[k]  = idle[k];
            fid[k]   = gid;
            fsbad[k] = (fs !== 1'b1);
            cap[k]   = '0;
            cap[k][0] = so;
            flen[k]  = 1;
            if (fe) finish_frame(k, 1'b0, cpb);
        end else begin
            idle[k]++;
        end
    endtask

    always @(negedge clk) begin
        mon(0, 1, sv1, so1, fs1, fe1, gid1);
        mon(1, 3, sv3, so3, fs3, fe3, gid3);
        chk("dut1_ready_onehot_to_valid", {59'b0, (rr1 & ~rv1), $onehot0(rr1)}, 64'h1);
        chk("dut3_ready_onehot_to_valid", {59'b0, (rr3 & ~rv3), $onehot0(rr3)}, 64'h1);
    end

    // Requester model: holds each word until accepted, then presents the next.
    initial begin
        logic [3:0] hs1, hs3;
        logic [7:0] junk;
        rv1 = '0; rd1 = '0; rv3 = '0; rd3 = '0;
        forever begin
            @(negedge clk);
            hs1 = rv1 & rr1;
            hs3 = rv3 & rr3;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (hs1[i] && wq1[i].size() > 0) junk = wq1[i].pop_front();
                if (hs3[i] && wq3[i].size() > 0) junk = wq3[i].pop_front();
                rv1[i] = (wq1[i].size() > 0);
                rd1[i*8 +: 8] = (wq1[i].size() > 0) ? wq1[i][0] : 8'h00;
                rv3[i] = (wq3[i].size() > 0);
                rd3[i*8 +: 8] = (wq3[i].size() > 0) ? wq3[i][0] : 8'h00;
            end
        end
    end

    function automatic bit all_idle();
        bit r;
        r = (exq1.size() == 0) && (exq3.size() == 0) && !inf[0] && !inf[1];
        for (int i = 0; i < 4; i++) r = r && (wq1[i].size() == 0) && (wq3[i].size() == 0);
        return r;
    endfunction

    task automatic wait_done(input string nm, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            #1;
            done = all_idle();
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s_complete: got still pending after %0d clocks want all frames done", nm, budget);
        end
    endtask

    task automatic wait_fs1(input string nm);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = (fs1 === 1'b1);
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_frame_start_timeout: got none want frame_start within 100 clocks", nm);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            cap[k] = '0; flen[k] = 0; inf[k] = 1'b0; idle[k] = 0; gapv[k] = 0; fid[k] = '0; fsbad[k] = 1'b0;
        end
        reset_n = 1'b0;
        flush   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("dut1_reset_outputs", 64'({so1, sv1, fs1, fe1, bz1, gid1, rr1}), 64'h0);
        chk("dut3_reset_outputs", 64'({so3, sv3, fs3, fe3, bz3, gid3, rr3}), 64'h0);
        reset_n = 1'b1;

        // Single word from req 0, and a stretched-bit frame on the slow instance.
        exq1.push_back(mk(2'd0, 8'hA5, 8, 1'b0, -1));
        wq1[0].push_back(8'hA5);
        exq3.push_back(mk(2'd0, 8'h01, 24, 1'b0, -1));
        wq3[0].push_back(8'h01);
        wait_done("single_and_slow", 200);

        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;

        // All four requesters valid continuously: 0,1,2,3 then 0 again.
        wq1[0].push_back(8'h11); wq1[0].push_back(8'h55);
        wq1[1].push_back(8'h22);
        wq1[2].push_back(8'h33);
        wq1[3].push_back(8'h44);
        exq1.push_back(mk(2'd0, 8'h11, 8, 1'b0, -1));
        exq1.push_back(mk(2'd1, 8'h22, 8, 1'b0, 1));
        exq1.push_back(mk(2'd2, 8'h33, 8, 1'b0, 1));
        exq1.push_back(mk(2'd3, 8'h44, 8, 1'b0, 1));
        exq1.push_back(mk(2'd0, 8'h55, 8, 1'b0, 1));
        wait_done("round_robin", 200);

        // Only req 2 valid: it is granted again after wrapping the search.
        wq1[2].push_back(8'h66); wq1[2].push_back(8'h77);
        exq1.push_back(mk(2'd2, 8'h66, 8, 1'b0, -1));
        exq1.push_back(mk(2'd2, 8'h77, 8, 1'b0, 1));
        wait_done("wrap_same_req", 200);

        // Flush at bit 2 of a req 0 frame; req 1 is next, then req 3.
        wq1[0].push_back(8'h88);
        exq1.push_back(mk(2'd0, 8'h88, 3, 1'b1, -1));
        wait_fs1("flush");
        wq1[1].push_back(8'h99);
        wq1[3].push_back(8'hBB);
        exq1.push_back(mk(2'd1, 8'h99, 8, 1'b0, 1));
        exq1.push_back(mk(2'd3, 8'hBB, 8, 1'b0, 1));
        @(posedge clk);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        wait_done("flush", 200);

        // Asynchronous reset at bit 4: outputs drop at once, word is not resent.
        wq1[2].push_back(8'hCC);
        exq1.push_back(mk(2'd2, 8'hCC, 4, 1'b1, -1));
        wait_fs1("async_reset");
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("dut1_async_reset_outputs", 64'({so1, sv1, fs1, fe1, bz1, gid1, rr1}), 64'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        wq1[1].push_back(8'hDD);
        wq1[0].push_back(8'hEE);
        exq1.push_back(mk(2'd0, 8'hEE, 8, 1'b0, -1));
        exq1.push_back(mk(2'd1, 8'hDD, 8, 1'b0, 1));
        wait_done("after_reset", 200);

        repeat (12) @(negedge clk);
        chk("leftover_expected_frames", 64'(exq1.size() + exq3.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
